// File: rtl/bram_portb_mmio.sv
// Port-B master for a CPU-shared BRAM: writes the button word, burst-reads the game state
// and publishes it as an atomic snapshot for the display logic, once per frame_start.
module bram_portb_mmio #(
  parameter logic [15:0] BASE_ADDR  = 16'h0100,
  parameter int          NUM_WORDS  = 4,
  parameter logic [15:0] INPUT_ADDR = 16'h00FF,
  parameter int          BTN_W      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic [BTN_W-1:0]          buttons,
  output logic [15:0]               addr_b,
  output logic [15:0]               data_b,
  output logic                      we_b,
  input  logic [15:0]               q_b,
  output logic [16*NUM_WORDS-1:0]   snap_data,
  output logic                      snap_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        idx;
  logic [BTN_W-1:0]        btn_q;
  logic [15:0]             stage [NUM_WORDS];
  logic [16*NUM_WORDS-1:0] snap_nxt;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_start) state_nxt = WRITE;
      WRITE:   state_nxt = READ;
      READ:    if (idx == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_b     = '0;
    data_b     = '0;
    we_b       = 1'b0;
    unique case (state)
      WRITE: begin
        addr_b = INPUT_ADDR;
        data_b = 16'(btn_q);
        we_b   = 1'b1;
      end
      READ:    addr_b = BASE_ADDR + 16'(idx);
      default: ;
    endcase
    snap_valid = (state == DONE);
    busy       = (state != IDLE);
  end

  // Last word comes straight from q_b so the whole snapshot lands on one edge.
  always_comb begin
    snap_nxt = '0;
    for (int i = 0; i < NUM_WORDS - 1; i++) snap_nxt[16*i +: 16] = stage[i];
    snap_nxt[16*(NUM_WORDS-1) +: 16] = q_b;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx       <= '0;
      btn_q     <= '0;
      overrun   <= 1'b0;
      snap_data <= '0;
      for (int i = 0; i < NUM_WORDS; i++) stage[i] <= '0;
    end else begin
      overrun <= frame_start && busy;
      if (state == IDLE && frame_start) btn_q <= buttons;
      if (state == READ) idx <= idx + 1'b1;
      else               idx <= '0;
      // Read data trails the address by one cycle.
      if (state == READ && idx != '0) stage[idx - 1'b1] <= q_b;
      if (state == DRAIN) begin
        stage[LAST_IDX] <= q_b;
        snap_data       <= snap_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bram_portb_mmio.sv
// Per-cycle vector table against two instances (default base and a base that wraps at 2^16).
module tb_bram_portb_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [3:0]  buttons;
  logic [15:0] addr0, data0, q0, addr1, data1, q1;
  logic        we0, we1, sv0, sv1, busy0, busy1, ovr0, ovr1;
  logic [63:0] snap0, snap1;
  logic [15:0] mem0 [0:65535];
  logic [15:0] mem1 [0:65535];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  bram_portb_mmio dut0 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .buttons(buttons),
    .addr_b(addr0), .data_b(data0), .we_b(we0), .q_b(q0),
    .snap_data(snap0), .snap_valid(sv0), .busy(busy0), .overrun(ovr0));

  bram_portb_mmio #(.BASE_ADDR(16'hFFFE)) dut1 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .buttons(buttons),
    .addr_b(addr1), .data_b(data1), .we_b(we1), .q_b(q1),
    .snap_data(snap1), .snap_valid(sv1), .busy(busy1), .overrun(ovr1));

  // Single-port synchronous BRAM models, read-before-write, 1-cycle latency.
  always @(posedge clk) begin
    if (we0) mem0[addr0] <= data0;
    q0 <= mem0[addr0];
    if (we1) mem1[addr1] <= data1;
    q1 <= mem1[addr1];
  end

  typedef struct {
    bit          rst;
    bit          fs;
    logic [3:0]  btn;
    bit          we;
    bit          ca;
    logic [15:0] addr;
    logic [15:0] data;
    bit          busy;
    bit          sv;
    bit          ovr;
    logic [63:0] snap;
  } vec_t;

  vec_t tbl[$];

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam logic [63:0] S0 = 64'h0;
  localparam logic [63:0] S1 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] S2 = 64'h8888_7777_6666_5555;
  localparam logic [63:0] S3 = 64'hCCCC_BBBB_AAAA_9999;

  function automatic vec_t r(bit rst, bit fs, logic [3:0] btn, bit we, bit ca,
                             logic [15:0] addr, logic [15:0] data, bit busy, bit sv,
                             bit ovr, logic [63:0] snap);
    vec_t v;
    v.rst = rst; v.fs = fs; v.btn = btn; v.we = we; v.ca = ca; v.addr = addr;
    v.data = data; v.busy = busy; v.sv = sv; v.ovr = ovr; v.snap = snap;
    return v;
  endfunction

  // Expected address of the wrapping instance: same offset from base FFFE.
  function automatic logic [15:0] wrap_addr(logic [15:0] a);
    if (a >= 16'h0100 && a <= 16'h0103) return 16'hFFFE + (a - 16'h0100);
    return a;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] base, input logic [63:0] w, input bit which);
    for (int k = 0; k < 4; k++) begin
      if (which) mem1[base + 16'(k)] <= w[16*k +: 16];
      else       mem0[base + 16'(k)] <= w[16*k +: 16];
    end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(posedge clk);
      #1;
      reset       = tbl[i].rst;
      frame_start = tbl[i].fs;
      buttons     = tbl[i].btn;
      @(negedge clk);
      chk($sformatf("row%0d we", i), 64'(we0), 64'(tbl[i].we));
      chk($sformatf("row%0d busy", i), 64'(busy0), 64'(tbl[i].busy));
      chk($sformatf("row%0d snap_valid", i), 64'(sv0), 64'(tbl[i].sv));
      chk($sformatf("row%0d overrun", i), 64'(ovr0), 64'(tbl[i].ovr));
      chk($sformatf("row%0d snap", i), snap0, tbl[i].snap);
      if (tbl[i].we || !tbl[i].busy)
        chk($sformatf("row%0d data", i), 64'(data0), 64'(tbl[i].data));
      if (tbl[i].ca) begin
        chk($sformatf("row%0d addr", i), 64'(addr0), 64'(tbl[i].addr));
        chk($sformatf("row%0d wrap_addr", i), 64'(addr1), 64'(wrap_addr(tbl[i].addr)));
      end
    end
  endtask

  initial begin
    int e2, e3, e6;
    reset = 1'b0; frame_start = 1'b0; buttons = 4'h0;
    for (int a = 0; a < 65536; a++) begin
      mem0[a] <= 16'h0;
      mem1[a] <= 16'h0;
    end
    #0;
    load(16'h0100, S1, 1'b0);
    load(16'hFFFE, 64'hD4D4_C3C3_B2B2_A1A1, 1'b1);

    // Basic transaction, buttons 1010.
    tbl.push_back(r(H,H,4'hA, L,H,16'h0000,16'h0000, L,L,L,S0));
    tbl.push_back(r(H,L,4'hA, H,H,16'h00FF,16'h000A, H,L,L,S0));
    tbl.push_back(r(H,L,4'hA, L,H,16'h0100,16'h0000, H,L,L,S0));
    tbl.push_back(r(H,L,4'hA, L,H,16'h0101,16'h0000, H,L,L,S0));
    tbl.push_back(r(H,L,4'hA, L,H,16'h0102,16'h0000, H,L,L,S0));
    tbl.push_back(r(H,L,4'hA, L,H,16'h0103,16'h0000, H,L,L,S0));
    tbl.push_back(r(H,L,4'hA, L,L,16'h0000,16'h0000, H,L,L,S0));
    tbl.push_back(r(H,L,4'hA, L,L,16'h0000,16'h0000, H,H,L,S1));
    tbl.push_back(r(H,L,4'hA, L,H,16'h0000,16'h0000, L,L,L,S1));
    e2 = tbl.size();
    // Overrun: second frame_start in cycle 3.
    tbl.push_back(r(H,H,4'h3, L,H,16'h0000,16'h0000, L,L,L,S1));
    tbl.push_back(r(H,L,4'h3, H,H,16'h00FF,16'h0003, H,L,L,S1));
    tbl.push_back(r(H,L,4'h3, L,H,16'h0100,16'h0000, H,L,L,S1));
    tbl.push_back(r(H,H,4'h3, L,H,16'h0101,16'h0000, H,L,L,S1));
    tbl.push_back(r(H,L,4'h3, L,H,16'h0102,16'h0000, H,L,H,S1));
    tbl.push_back(r(H,L,4'h3, L,H,16'h0103,16'h0000, H,L,L,S1));
    tbl.push_back(r(H,L,4'h3, L,L,16'h0000,16'h0000, H,L,L,S1));
    tbl.push_back(r(H,L,4'h3, L,L,16'h0000,16'h0000, H,H,L,S2));
    tbl.push_back(r(H,L,4'h3, L,H,16'h0000,16'h0000, L,L,L,S2));
    e3 = tbl.size();
    // Buttons change after acceptance; back-to-back frame in first IDLE after DONE.
    tbl.push_back(r(H,H,4'h1, L,H,16'h0000,16'h0000, L,L,L,S2));
    tbl.push_back(r(H,L,4'hF, H,H,16'h00FF,16'h0001, H,L,L,S2));
    tbl.push_back(r(H,L,4'hF, L,H,16'h0100,16'h0000, H,L,L,S2));
    tbl.push_back(r(H,L,4'hF, L,H,16'h0101,16'h0000, H,L,L,S2));
    tbl.push_back(r(H,L,4'hF, L,H,16'h0102,16'h0000, H,L,L,S2));
    tbl.push_back(r(H,L,4'hF, L,H,16'h0103,16'h0000, H,L,L,S2));
    tbl.push_back(r(H,L,4'hF, L,L,16'h0000,16'h0000, H,L,L,S2));
    tbl.push_back(r(H,L,4'hF, L,L,16'h0000,16'h0000, H,H,L,S2));
    tbl.push_back(r(H,H,4'h6, L,H,16'h0000,16'h0000, L,L,L,S2));
    tbl.push_back(r(H,L,4'hF, H,H,16'h00FF,16'h0006, H,L,L,S2));
    tbl.push_back(r(H,L,4'hF, L,H,16'h0100,16'h0000, H,L,L,S2));
    tbl.push_back(r(H,L,4'hF, L,H,16'h0101,16'h0000, H,L,L,S2));
    tbl.push_back(r(H,L,4'hF, L,H,16'h0102,16'h0000, H,L,L,S2));
    tbl.push_back(r(H,L,4'hF, L,H,16'h0103,16'h0000, H,L,L,S2));
    tbl.push_back(r(H,L,4'hF, L,L,16'h0000,16'h0000, H,L,L,S2));
    tbl.push_back(r(H,L,4'hF, L,L,16'h0000,16'h0000, H,H,L,S2));
    tbl.push_back(r(H,L,4'hF, L,H,16'h0000,16'h0000, L,L,L,S2));
    e6 = tbl.size();
    // Reset asserted mid-READ in cycle 4, then a clean transaction.
    tbl.push_back(r(H,H,4'h5, L,H,16'h0000,16'h0000, L,L,L,S2));
    tbl.push_back(r(H,L,4'h5, H,H,16'h00FF,16'h0005, H,L,L,S2));
    tbl.push_back(r(H,L,4'h5, L,H,16'h0100,16'h0000, H,L,L,S2));
    tbl.push_back(r(H,L,4'h5, L,H,16'h0101,16'h0000, H,L,L,S2));
    tbl.push_back(r(L,L,4'h5, L,H,16'h0102,16'h0000, H,L,L,S2));
    tbl.push_back(r(H,L,4'h5, L,H,16'h0000,16'h0000, L,L,L,S0));
    tbl.push_back(r(H,L,4'h5, L,H,16'h0000,16'h0000, L,L,L,S0));
    tbl.push_back(r(H,H,4'hC, L,H,16'h0000,16'h0000, L,L,L,S0));
    tbl.push_back(r(H,L,4'h0, H,H,16'h00FF,16'h000C, H,L,L,S0));
    tbl.push_back(r(H,L,4'h0, L,H,16'h0100,16'h0000, H,L,L,S0));
    tbl.push_back(r(H,L,4'h0, L,H,16'h0101,16'h0000, H,L,L,S0));
    tbl.push_back(r(H,L,4'h0, L,H,16'h0102,16'h0000, H,L,L,S0));
    tbl.push_back(r(H,L,4'h0, L,H,16'h0103,16'h0000, H,L,L,S0));
    tbl.push_back(r(H,L,4'h0, L,L,16'h0000,16'h0000, H,L,L,S0));
    tbl.push_back(r(H,L,4'h0, L,L,16'h0000,16'h0000, H,H,L,S3));
    tbl.push_back(r(H,L,4'h0, L,H,16'h0000,16'h0000, L,L,L,S3));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset we", 64'(we0), 64'h0);
    chk("reset addr", 64'(addr0), 64'h0);
    chk("reset data", 64'(data0), 64'h0);
    chk("reset busy", 64'(busy0), 64'h0);
    chk("reset snap_valid", 64'(sv0), 64'h0);
    chk("reset overrun", 64'(ovr0), 64'h0);
    chk("reset snap", snap0, 64'h0);

    run(0, e2);
    chk("wrap snap", snap1, 64'hD4D4_C3C3_B2B2_A1A1);
    chk("button word in bram", 64'(mem0[16'h00FF]), 64'h000A);
    load(16'h0100, S2, 1'b0);
    run(e2, e3);
    run(e3, e6);
    chk("latched button word", 64'(mem0[16'h00FF]), 64'h0006);
    load(16'h0100, S3, 1'b0);
    run(e6, tbl.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
